mpu6050_burst_reader: RTL and testbench

Parametrised MPU6050 sensor-block reader. It fetches 2×NUM_CH consecutive registers starting at BASE_ADDR over a byte-level request/acknowledge handshake to the I2C master. It assembles big-endian 16-bit channel words and publishes all channels atomically with a one-cycle valid strobe. The block sits between the I2C byte engine and the attitude-solver datapath, and supports single-shot or periodic (continuous) acquisition with timeout and error abort.

---
 rtl/mpu6050_pkg.sv | 21 ++
 rtl/mpu6050_burst_reader_if.sv | 27 ++
 rtl/mpu6050_period_timer.sv | 42 ++++
 rtl/mpu6050_burst_reader.sv | 142 ++++++++++++++
 tb/tb_mpu6050_burst_reader.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mpu6050_pkg.sv
// Shared definitions for the MPU6050 burst readers: register map, FSM states
// and the channel bit-offset helper.
package mpu6050_pkg;

    localparam logic [7:0] ACCEL_XOUT_H = 8'h3B;
    localparam logic [7:0] TEMP_OUT_H   = 8'h41;
    localparam logic [7:0] GYRO_XOUT_H  = 8'h43;
    localparam logic [7:0] GYRO_ZOUT_L  = 8'h48;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DONE  = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    function automatic int unsigned ch_base(input int unsigned k);
        return 32'd16 * k;
    endfunction

endpackage

// File: rtl/mpu6050_burst_reader_if.sv
// Byte-level request/acknowledge link between a burst reader (master) and
// the I2C byte engine (slave).
interface mpu6050_burst_reader_if;

    logic       byte_req;
    logic [7:0] byte_addr;
    logic       byte_ack;
    logic [7:0] byte_data;
    logic       byte_err;

    modport master (
        output byte_req,
        output byte_addr,
        input  byte_ack,
        input  byte_data,
        input  byte_err
    );

    modport slave (
        input  byte_req,
        input  byte_addr,
        output byte_ack,
        output byte_data,
        output byte_err
    );

endinterface

// File: rtl/mpu6050_period_timer.sv
// Free-running burst-start timer: one-cycle tick every `period` cycles while
// cont_en is high; a period of zero behaves as one.
module mpu6050_period_timer #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cont_en,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    logic [PERIOD_W-1:0] cnt_r;
    logic [PERIOD_W-1:0] last_s;

    // Terminal count for the current period setting.
    always_comb begin
        if (period == {PERIOD_W{1'b0}}) begin
            last_s = {PERIOD_W{1'b0}};
        end else begin
            last_s = period - {{(PERIOD_W-1){1'b0}}, 1'b1};
        end
    end

    // Counter restarts whenever continuous mode is disabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {PERIOD_W{1'b0}};
            tick  <= 1'b0;
        end else if (!cont_en) begin
            cnt_r <= {PERIOD_W{1'b0}};
            tick  <= 1'b0;
        end else if (cnt_r >= last_s) begin
            cnt_r <= {PERIOD_W{1'b0}};
            tick  <= 1'b1;
        end else begin
            cnt_r <= cnt_r + {{(PERIOD_W-1){1'b0}}, 1'b1};
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/mpu6050_burst_reader.sv
// Reads 2*NUM_CH consecutive MPU6050 registers, assembles big-endian channel
// words in a shadow and publishes them atomically with a data_valid strobe.
module mpu6050_burst_reader
    import mpu6050_pkg::*;
#(
    parameter int         NUM_CH      = 3,
    parameter logic [7:0] BASE_ADDR   = 8'h43,
    parameter int         PERIOD_W    = 24,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   cont_en,
    input  logic [PERIOD_W-1:0]    period,
    mpu6050_burst_reader_if.master bus,
    output logic [16*NUM_CH-1:0]   ch_data,
    output logic                   data_valid,
    output logic                   busy,
    output logic                   err,
    output logic                   overrun
);

    localparam int NBYTES = 2 * NUM_CH;
    localparam int IDX_W  = $clog2(NBYTES);
    localparam int OFF_W  = $clog2(16 * NUM_CH);
    localparam int TO_W   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

    state_t                state_r;
    logic [IDX_W-1:0]      idx_r;
    logic [TO_W-1:0]       to_cnt_r;
    logic [16*NUM_CH-1:0]  shadow_r;
    logic [16*NUM_CH-1:0]  shadow_next_s;
    logic [OFF_W-1:0]      byte_off_s;
    logic                  tick_s;
    logic                  tick_ok_s;

    mpu6050_period_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .cont_en (cont_en),
        .period  (period),
        .tick    (tick_s)
    );

    assign tick_ok_s = tick_s & cont_en;

    // Even byte index lands in the channel's high byte, odd in its low byte.
    always_comb begin
        byte_off_s    = OFF_W'(ch_base(32'(idx_r >> 1)) + (idx_r[0] ? 32'd0 : 32'd8));
        shadow_next_s = shadow_r;
        shadow_next_s[byte_off_s +: 8] = bus.byte_data;
    end

    // Burst FSM with all outputs registered; the last byte is merged on the
    // fly so ch_data and data_valid appear the cycle after the final ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            idx_r         <= {IDX_W{1'b0}};
            to_cnt_r      <= {TO_W{1'b0}};
            shadow_r      <= {(16*NUM_CH){1'b0}};
            ch_data       <= {(16*NUM_CH){1'b0}};
            data_valid    <= 1'b0;
            busy          <= 1'b0;
            err           <= 1'b0;
            overrun       <= 1'b0;
            bus.byte_req  <= 1'b0;
            bus.byte_addr <= BASE_ADDR;
        end else begin
            if (tick_ok_s && busy) begin
                overrun <= 1'b1;
            end else if (start) begin
                overrun <= 1'b0;
            end else begin
                overrun <= overrun;
            end

            case (state_r)
                ST_IDLE: begin
                    if (start || tick_ok_s) begin
                        state_r       <= ST_REQ;
                        idx_r         <= {IDX_W{1'b0}};
                        to_cnt_r      <= {TO_W{1'b0}};
                        busy          <= 1'b1;
                        bus.byte_req  <= 1'b1;
                        bus.byte_addr <= BASE_ADDR;
                    end
                end
                ST_REQ: begin
                    if (!bus.byte_req) begin
                        bus.byte_req <= 1'b1;
                    end else if (bus.byte_err) begin
                        state_r      <= ST_ABORT;
                        err          <= 1'b1;
                        bus.byte_req <= 1'b0;
                    end else if (bus.byte_ack) begin
                        shadow_r     <= shadow_next_s;
                        bus.byte_req <= 1'b0;
                        if (idx_r == LAST_IDX) begin
                            state_r    <= ST_DONE;
                            ch_data    <= shadow_next_s;
                            data_valid <= 1'b1;
                        end else begin
                            idx_r         <= idx_r + IDX_W'(1);
                            to_cnt_r      <= {TO_W{1'b0}};
                            bus.byte_addr <= BASE_ADDR + 8'(idx_r) + 8'd1;
                        end
                    end else if (to_cnt_r == TO_LAST) begin
                        state_r      <= ST_ABORT;
                        err          <= 1'b1;
                        bus.byte_req <= 1'b0;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                    end
                end
                ST_DONE: begin
                    data_valid    <= 1'b0;
                    busy          <= 1'b0;
                    bus.byte_addr <= BASE_ADDR;
                    state_r       <= ST_IDLE;
                end
                ST_ABORT: begin
                    err           <= 1'b0;
                    busy          <= 1'b0;
                    bus.byte_addr <= BASE_ADDR;
                    state_r       <= ST_IDLE;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    bus.byte_req <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpu6050_burst_reader.sv
// Directed bench: a 3-channel gyro reader (short timeout, continuous mode) and
// a 7-channel accel/temp/gyro reader, both served by a scripted byte slave.
module tb_mpu6050_burst_reader;
    import mpu6050_pkg::*;

    logic         clk;
    logic         rst;
    logic         start_a, start_b, cont_a, cont_b;
    logic [23:0]  period_a, period_b;
    logic [47:0]  ch_a;
    logic [111:0] ch_b;
    logic         dv_a, busy_a, err_a, ovr_a;
    logic         dv_b, busy_b, err_b, ovr_b;
    logic [7:0]   tab [14];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int dv_cnt_a = 0, dv_cyc_a = 0, dv_prev_a = 0, dv_cnt_b = 0;
    int cs, hi;

    mpu6050_burst_reader_if bus_a ();
    mpu6050_burst_reader_if bus_b ();

    mpu6050_burst_reader #(
        .NUM_CH(3), .BASE_ADDR(GYRO_XOUT_H), .PERIOD_W(24), .TIMEOUT_CYC(8)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .cont_en(cont_a), .period(period_a),
        .bus(bus_a), .ch_data(ch_a), .data_valid(dv_a), .busy(busy_a), .err(err_a),
        .overrun(ovr_a)
    );

    mpu6050_burst_reader #(
        .NUM_CH(7), .BASE_ADDR(ACCEL_XOUT_H), .PERIOD_W(24), .TIMEOUT_CYC(100000)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .cont_en(cont_b), .period(period_b),
        .bus(bus_b), .ch_data(ch_b), .data_valid(dv_b), .busy(busy_b), .err(err_b),
        .overrun(ovr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dv_a) begin
            dv_cnt_a  = dv_cnt_a + 1;
            dv_prev_a = dv_cyc_a;
            dv_cyc_a  = cyc;
        end
        if (dv_b) dv_cnt_b = dv_cnt_b + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog bench did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [111:0] obs, input logic [111:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic req_of(input bit b);
        return b ? bus_b.byte_req : bus_a.byte_req;
    endfunction

    function automatic logic [111:0] ch_of(input bit b);
        return b ? ch_b : {64'd0, ch_a};
    endfunction

    // Scripted slave: answers n requests from tab[], optional random wait,
    // err_at < 0 means no error; both=1 raises ack together with err.
    task automatic serve(input bit on_b, input int n, input int maxdly, input int err_at,
                         input bit both, input logic [111:0] ch_before);
        int w;
        int dly;
        int nb;
        logic [7:0] base;
        base = on_b ? ACCEL_XOUT_H : GYRO_XOUT_H;
        nb   = on_b ? 14 : 6;
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (!req_of(on_b) && w < 60) begin
                @(negedge clk);
                w++;
            end
            check("req_up", req_of(on_b), 1'b1);
            check("addr", on_b ? bus_b.byte_addr : bus_a.byte_addr, base + 8'(i));
            dly = (maxdly > 0) ? int'($urandom_range(maxdly, 0)) : 0;
            repeat (dly) @(negedge clk);
            if (i == nb - 1) begin
                check("hold_ch", ch_of(on_b), ch_before);
                check("dv_quiet", on_b ? dv_b : dv_a, 1'b0);
            end
            if (on_b) begin
                bus_b.byte_data = tab[i];
                bus_b.byte_ack  = (i != err_at) || both;
                bus_b.byte_err  = (i == err_at);
            end else begin
                bus_a.byte_data = tab[i];
                bus_a.byte_ack  = (i != err_at) || both;
                bus_a.byte_err  = (i == err_at);
            end
            @(negedge clk);
            bus_a.byte_ack = 1'b0; bus_a.byte_err = 1'b0;
            bus_b.byte_ack = 1'b0; bus_b.byte_err = 1'b0;
            if (i == err_at) return;
            if (i < nb - 1) check("req_gap", req_of(on_b), 1'b0);
        end
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic load_gyro_tab();
        tab[0] = 8'h12; tab[1] = 8'h34; tab[2] = 8'h56;
        tab[3] = 8'h78; tab[4] = 8'h9A; tab[5] = 8'hBC;
    endtask

    initial begin
        rst = 1'b0;
        start_a = 1'b0; start_b = 1'b0; cont_a = 1'b0; cont_b = 1'b0;
        period_a = 24'd0; period_b = 24'd0;
        bus_a.byte_ack = 1'b0; bus_a.byte_err = 1'b0; bus_a.byte_data = 8'h00;
        bus_b.byte_ack = 1'b0; bus_b.byte_err = 1'b0; bus_b.byte_data = 8'h00;
        repeat (2) @(negedge clk);

        check("rst_req_a", bus_a.byte_req, 1'b0);
        check("rst_addr_a", bus_a.byte_addr, 8'h43);
        check("rst_addr_b", bus_b.byte_addr, 8'h3B);
        check("rst_ch_a", ch_a, 48'd0);
        check("rst_ch_b", ch_b, 112'd0);
        check("rst_flags_a", {dv_a, busy_a, err_a, ovr_a}, 4'b0000);
        check("rst_flags_b", {dv_b, busy_b, err_b, ovr_b, bus_b.byte_req}, 5'b00000);
        rst = 1'b1;
        @(negedge clk);

        // Zero-wait 3-channel burst; start cycle counts as cycle 1, data_valid in cycle 13.
        load_gyro_tab();
        cs = cyc;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("launch_busy", busy_a, 1'b1);
        serve(1'b0, 6, 0, -1, 1'b0, 112'd0);
        check("t1_dv", dv_a, 1'b1);
        check("t1_ch", ch_a, 48'h9ABC_5678_1234);
        check("t1_busy_done", busy_a, 1'b1);
        @(negedge clk);
        check("t1_busy_off", busy_a, 1'b0);
        check("t1_dv_off", dv_a, 1'b0);
        check("t1_dv_count", dv_cnt_a, 1);
        check("t1_latency", dv_cyc_a - cs, 12);

        // 7-channel burst with random ack latency.
        for (int i = 0; i < 14; i++) tab[i] = 8'hA0 + 8'(i);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        serve(1'b1, 14, 5, -1, 1'b0, 112'd0);
        check("t2_dv", dv_b, 1'b1);
        check("t2_ch", ch_b, 112'hACAD_AAAB_A8A9_A6A7_A4A5_A2A3_A0A1);
        check("t2_temp", ch_b[63:48], 16'hA6A7);
        @(negedge clk);
        check("t2_dv_count", dv_cnt_b, 1);
        check("t2_busy_off", busy_b, 1'b0);

        // byte_err on the 4th byte.
        load_gyro_tab();
        pulse_start_a();
        serve(1'b0, 6, 0, 3, 1'b0, 112'h9ABC_5678_1234);
        check("t3_err", err_a, 1'b1);
        check("t3_busy", busy_a, 1'b1);
        check("t3_dv", dv_a, 1'b0);
        @(negedge clk);
        check("t3_busy_off", {busy_a, err_a}, 2'b00);
        check("t3_ch_kept", ch_a, 48'h9ABC_5678_1234);
        check("t3_dv_count", dv_cnt_a, 1);

        // ack and err in the same cycle are an error.
        pulse_start_a();
        serve(1'b0, 6, 0, 0, 1'b1, 112'h9ABC_5678_1234);
        check("t4_err", err_a, 1'b1);
        @(negedge clk);
        check("t4_busy_off", busy_a, 1'b0);
        check("t4_ch_kept", ch_a, 48'h9ABC_5678_1234);
        check("t4_dv_count", dv_cnt_a, 1);

        // No ack at all: request stays up exactly TIMEOUT_CYC=8 cycles.
        pulse_start_a();
        hi = 0;
        while (bus_a.byte_req && hi < 30) begin
            hi++;
            @(negedge clk);
        end
        check("t5_req_cycles", hi, 8);
        check("t5_err", err_a, 1'b1);
        @(negedge clk);
        check("t5_idle", {busy_a, err_a}, 2'b00);

        // Continuous mode, period 40: bursts 40 cycles apart, no overrun.
        period_a = 24'd40;
        cont_a   = 1'b1;
        for (int k = 0; k < 3; k++) serve(1'b0, 6, 0, -1, 1'b0, 112'h9ABC_5678_1234);
        cont_a = 1'b0;
        @(negedge clk);
        check("t6_spacing", dv_cyc_a - dv_prev_a, 40);
        check("t6_overrun", ovr_a, 1'b0);
        check("t6_dv_count", dv_cnt_a, 4);

        // Period 5 is shorter than a burst: ticks dropped, overrun sticky.
        period_a = 24'd5;
        cont_a   = 1'b1;
        serve(1'b0, 6, 0, -1, 1'b0, 112'h9ABC_5678_1234);
        cont_a = 1'b0;
        repeat (3) @(negedge clk);
        check("t7_overrun", ovr_a, 1'b1);
        check("t7_dv_count", dv_cnt_a, 5);
        check("t7_idle", busy_a, 1'b0);
        pulse_start_a();
        check("t7_ovr_clear", ovr_a, 1'b0);
        serve(1'b0, 6, 0, -1, 1'b0, 112'h9ABC_5678_1234);
        @(negedge clk);

        // Reset while byte 3 is requested, then a fresh burst.
        pulse_start_a();
        serve(1'b0, 3, 0, -1, 1'b0, 112'd0);
        @(negedge clk);
        check("t8_byte3", {bus_a.byte_req, bus_a.byte_addr}, {1'b1, 8'h46});
        rst = 1'b0;
        #1;
        check("t8_rst_req", bus_a.byte_req, 1'b0);
        check("t8_rst_addr", bus_a.byte_addr, 8'h43);
        check("t8_rst_ch", ch_a, 48'd0);
        check("t8_rst_flags", {dv_a, busy_a, err_a, ovr_a}, 4'b0000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tab[0] = 8'h11; tab[1] = 8'h22; tab[2] = 8'h33;
        tab[3] = 8'h44; tab[4] = 8'h55; tab[5] = 8'h66;
        pulse_start_a();
        serve(1'b0, 6, 0, -1, 1'b0, 112'd0);
        check("t8_dv", dv_a, 1'b1);
        check("t8_ch", ch_a, 48'h5566_3344_1122);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
